// File: rtl/tx_engine.sv
// UART transmit engine: one byte per load, 11-bit-time frame LSB first on tx.
// Optional parity generation is compiled in when TX_PARITY_EN is defined.
module tx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] k,
    input  logic        load,
    input  logic [7:0]  out_port,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    output logic        txrdy,
    output logic        tx
);
    typedef enum logic [1:0] {IDLE, BUILD, SEND} state_t;

    state_t      state, state_nxt;
    logic        doit;
    logic        accept;
    logic        btu;
    logic [7:0]  data_l;
    logic        eight_l;
    logic [19:0] k_l;
    logic [10:0] shift;
    logic [19:0] bt_cnt;
    logic [3:0]  bit_cnt;
    logic        b8, b9;

    assign accept = load & txrdy;
    assign btu    = doit & (bt_cnt == k_l - 20'd1);
    assign tx     = shift[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = BUILD;
            BUILD:   state_nxt = SEND;
            SEND:    if (btu && bit_cnt == 4'd10) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        txrdy = (state == IDLE);
        doit  = (state == SEND);
    end

`ifdef TX_PARITY_EN
    logic       pen_l, ohel_l;
    logic [7:0] par_bits;
    logic       par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pen_l  <= 1'b0;
            ohel_l <= 1'b0;
        end else if (accept) begin
            pen_l  <= pen;
            ohel_l <= ohel;
        end
    end

    // Bit 7 only participates in parity for 8-bit characters.
    always_comb begin
        par_bits = eight_l ? data_l : {1'b0, data_l[6:0]};
        par      = ohel_l ? ~^par_bits : ^par_bits;
        b8       = eight_l ? data_l[7] : (pen_l ? par : 1'b1);
        b9       = (eight_l & pen_l) ? par : 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = pen ^ ohel;

    always_comb begin
        b8 = eight_l ? data_l[7] : 1'b1;
        b9 = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_l  <= 8'h00;
            eight_l <= 1'b0;
            k_l     <= 20'd2;
            shift   <= '1;
            bt_cnt  <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                data_l  <= out_port;
                eight_l <= eight;
                k_l     <= (k < 20'd2) ? 20'd2 : k;
            end
            if (state == BUILD) begin
                shift   <= {1'b1, b9, b8, data_l[6:0], 1'b0};
                bt_cnt  <= '0;
                bit_cnt <= '0;
            end else if (doit) begin
                if (btu) begin
                    // Ones shifted in leave the line idle-high once the frame drains.
                    bt_cnt  <= '0;
                    shift   <= {1'b1, shift[10:1]};
                    bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    bt_cnt  <= bt_cnt + 20'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_engine.sv
// Bench for tx_engine: directed and random frames checked clock-by-clock
// against a frame model built from popcount parity rules.
module tb_tx_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] k;
    logic        load;
    logic [7:0]  out_port;
    logic        eight, pen, ohel;
    logic        txrdy, tx;

    int checks = 0;
    int errors = 0;

    tx_engine dut (
        .clk(clk), .reset(reset), .k(k), .load(load), .out_port(out_port),
        .eight(eight), .pen(pen), .ohel(ohel), .txrdy(txrdy), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        logic b8, b9;
`ifdef TX_PARITY_EN
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++)
            if (i < 7 || e) ones += int'(d[i]);
        par = o ? (ones % 2 == 0) : (ones % 2 == 1);
        if (e) begin b8 = d[7]; b9 = p ? par : 1'b1; end
        else   begin b8 = p ? par : 1'b1; b9 = 1'b1; end
`else
        b8 = e ? d[7] : 1'b1;
        b9 = 1'b1;
        if (p ^ o) b9 = 1'b1;
`endif
        return {1'b1, b9, b8, d[6:0], 1'b0};
    endfunction

    // Sends one frame and checks tx on every clock of it; optionally pulses a
    // second load (with other data and a new k) at frame clock inj_at.
    task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                        input logic [19:0] kv, input int inj_at, input logic [19:0] newk);
        logic [10:0] f;
        int kl;
        f  = model_frame(d, e, p, o);
        kl = (kv < 2) ? 2 : int'(kv);
        chk("txrdy_before", txrdy, 1);
        out_port = d; eight = e; pen = p; ohel = o; k = kv; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("txrdy_accept", txrdy, 0);
        chk("tx_accept", tx, 1);
        out_port = 8'($urandom); eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < 11 * kl; i++) begin
            chk("tx_bit", tx, f[i / kl]);
            chk("txrdy_busy", txrdy, 0);
            load = (i == inj_at);
            if (i == inj_at) begin
                out_port = ~d;
                k = newk;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        chk("txrdy_done", txrdy, 1);
        chk("tx_idle", tx, 1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; k = 20'd4; out_port = 8'h00;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        #12;
        chk("rst_tx", tx, 1);
        chk("rst_txrdy", txrdy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        send(8'h41, 1, 1, 0, 20'd4, -1, 20'd0);
        send(8'h41, 0, 1, 1, 20'd4, -1, 20'd0);
        send(8'h5A, 1, 0, 0, 20'd4, 20, 20'd8);
        send(8'h33, 1, 1, 1, 20'd8, -1, 20'd0);
        send(8'hC3, 0, 0, 0, 20'd0, -1, 20'd0);
        send(8'hFF, 1, 1, 0, 20'd1, 7, 20'd3);
        send(8'hFF, 1, 1, 0, 20'd4, -1, 20'd0);

        // reset while idle
        #2 reset = 1'b1;
        #1 chk("rst_idle_tx", tx, 1);
        chk("rst_idle_txrdy", txrdy, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // reset during the start bit of a frame
        out_port = 8'h00; eight = 1'b1; k = 20'd4; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_start", tx, 0);
        #2 reset = 1'b1;
        #1 chk("rst_mid_tx", tx, 1);
        chk("rst_mid_txrdy", txrdy, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        send(8'hA5, 1, 1, 1, 20'd3, -1, 20'd0);

        for (int n = 0; n < 8; n++) begin
            logic [7:0]  rd;
            logic [19:0] rk;
            rd = 8'($urandom);
            rk = 20'($urandom_range(0, 6));
            send(rd, 1'($urandom), 1'($urandom), 1'($urandom), rk,
                 int'($urandom_range(0, 40)), 20'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
